// File: rtl/uart_hex_tx_sequencer.sv
// Renders one accepted byte as two ASCII hex chars (plus optional CR LF) into a UART_TX.
// Latency: first o_TX_DV two edges after i_DV when the transmitter is idle; one GAP per char.
// Backpressure: o_Ready only in IDLE; i_DV while busy is dropped and flagged on o_Overrun.
module uart_hex_tx_sequencer #(
  parameter bit APPEND_CRLF = 1'b1,
  parameter bit UPPERCASE   = 1'b1
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_DV,
  input  logic [7:0] i_Byte,
  output logic       o_Ready,
  output logic       o_Overrun,
  output logic       o_TX_DV,
  output logic [7:0] o_TX_Byte,
  input  logic       i_TX_Active,
  input  logic       i_TX_Done
);

  typedef enum logic [1:0] {IDLE, GAP, STROBE, WAIT_DONE} state_t;

  localparam logic [1:0] LAST_IDX = APPEND_CRLF ? 2'd3 : 2'd1;

  state_t     state, state_nxt;
  logic [1:0] idx, idx_nxt;
  logic [7:0] byte_q, byte_nxt;
  logic [7:0] char_cur;
  logic       ready_nxt, overrun_nxt, tx_dv_nxt;
  logic [7:0] tx_byte_nxt;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return (UPPERCASE ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
  endfunction

  always_comb begin
    case (idx)
      2'd0:    char_cur = hex_char(byte_q[7:4]);
      2'd1:    char_cur = hex_char(byte_q[3:0]);
      2'd2:    char_cur = 8'h0D;
      default: char_cur = 8'h0A;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state     <= IDLE;
      idx       <= 2'd0;
      byte_q    <= 8'h00;
      o_Ready   <= 1'b1;
      o_Overrun <= 1'b0;
      o_TX_DV   <= 1'b0;
      o_TX_Byte <= 8'h00;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      byte_q    <= byte_nxt;
      o_Ready   <= ready_nxt;
      o_Overrun <= overrun_nxt;
      o_TX_DV   <= tx_dv_nxt;
      o_TX_Byte <= tx_byte_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    byte_nxt  = byte_q;
    case (state)
      IDLE: begin
        if (i_DV) begin
          state_nxt = GAP;
          idx_nxt   = 2'd0;
          byte_nxt  = i_Byte;
        end
      end
      // Hold off until the transmitter has fully finished, including its Done cleanup.
      GAP: begin
        if (!i_TX_Active && !i_TX_Done) state_nxt = STROBE;
      end
      STROBE: state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (i_TX_Done) begin
          if (idx == LAST_IDX) begin
            state_nxt = IDLE;
          end else begin
            idx_nxt   = idx + 2'd1;
            state_nxt = GAP;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs are computed from the next state so they line up with it.
  always_comb begin
    ready_nxt   = (state_nxt == IDLE);
    overrun_nxt = i_DV && (state != IDLE);
    tx_dv_nxt   = (state_nxt == STROBE);
    tx_byte_nxt = tx_dv_nxt ? char_cur : o_TX_Byte;
  end

endmodule

// File: tb/tb_uart_hex_tx_sequencer.sv
// Bench: two sequencers (CRLF+upper, no-CRLF+lower) against modelled UART_TX and a transaction model.
module tb_uart_hex_tx_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] dv, ready, ov, txdv, act, done;
  logic [7:0] byt [2];
  logic [7:0] txb [2];

  always #20 clk = ~clk;

  uart_hex_tx_sequencer #(.APPEND_CRLF(1'b1), .UPPERCASE(1'b1)) u_dut0 (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_DV(dv[0]), .i_Byte(byt[0]),
    .o_Ready(ready[0]), .o_Overrun(ov[0]), .o_TX_DV(txdv[0]), .o_TX_Byte(txb[0]),
    .i_TX_Active(act[0]), .i_TX_Done(done[0]));

  uart_hex_tx_sequencer #(.APPEND_CRLF(1'b0), .UPPERCASE(1'b0)) u_dut1 (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_DV(dv[1]), .i_Byte(byt[1]),
    .o_Ready(ready[1]), .o_Overrun(ov[1]), .o_TX_DV(txdv[1]), .o_TX_Byte(txb[1]),
    .i_TX_Active(act[1]), .i_TX_Done(done[1]));

  // Transaction model: expected character stream, readiness and overrun per instance.
  logic       m_ready [2];
  logic       m_ov    [2];
  logic       m_await [2];
  logic [7:0] m_hold  [2];
  int         m_left  [2];
  logic       m_acc;
  logic [7:0] exp_q   [2][$];

  function automatic logic [7:0] hexc(input logic [3:0] n, input bit upper);
    string s;
    s = upper ? "0123456789ABCDEF" : "0123456789abcdef";
    return s[n];
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_ready[d] = 1'b1; m_ov[d] = 1'b0; m_await[d] = 1'b0;
        m_hold[d] = 8'h00; m_left[d] = 0; exp_q[d].delete();
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        m_acc   = dv[d] && m_ready[d];
        m_ov[d] = dv[d] && !m_ready[d];
        if (m_await[d] && done[d]) begin
          m_await[d] = 1'b0;
          m_left[d]--;
          if (m_left[d] == 0) m_ready[d] = 1'b1;
        end
        if (txdv[d]) begin
          m_await[d] = 1'b1;
          if (exp_q[d].size() > 0) m_hold[d] = exp_q[d].pop_front();
        end
        if (m_acc) begin
          exp_q[d].push_back(hexc(byt[d][7:4], d == 0));
          exp_q[d].push_back(hexc(byt[d][3:0], d == 0));
          if (d == 0) begin
            exp_q[d].push_back(8'h0D);
            exp_q[d].push_back(8'h0A);
          end
          m_left[d]  = (d == 0) ? 4 : 2;
          m_ready[d] = 1'b0;
        end
      end
    end
  end

  int         errors = 0;
  int         checks = 0;
  int         ovcnt [2];
  logic [7:0] cap   [2][$];
  logic [1:0] prev_dv;
  int         tt [2], ta [2], td [2], th [2];
  bit         spur_en, force_slow;
  int         n;

  task automatic chk(input string name, input int d, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s [dut%0d]: got %0h, required %0h", name, d, act_v, exp_v);
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      chk("ready", d, ready[d], m_ready[d]);
      chk("overrun", d, ov[d], m_ov[d]);
      if (ov[d]) ovcnt[d]++;
      if (txdv[d] === 1'b1) begin
        chk("strobe_has_expected_char", d, exp_q[d].size() > 0, 1);
        if (exp_q[d].size() > 0) chk("strobe_byte", d, txb[d], exp_q[d][0]);
        chk("strobe_tx_idle", d, {act[d], done[d]}, 0);
        chk("strobe_not_waiting_done", d, m_await[d], 0);
        chk("strobe_one_cycle", d, prev_dv[d], 0);
        cap[d].push_back(txb[d]);
      end else begin
        chk("tx_byte_hold", d, txb[d], m_hold[d]);
      end
      prev_dv[d] = txdv[d];
    end
  endtask

  // Modelled UART_TX: Active for ta cycles, then Done for td cycles, Active optionally lingering.
  task automatic tx_step();
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        tt[d] = -1; act[d] = 1'b0; done[d] = 1'b0;
      end else begin
        if (txdv[d]) begin
          tt[d] = 0;
          ta[d] = $urandom_range(1, 6);
          td[d] = force_slow ? 3 : $urandom_range(1, 3);
          th[d] = force_slow ? 5 : $urandom_range(0, td[d] + 2);
        end else if (tt[d] >= 0) begin
          tt[d]++;
          if (tt[d] >= ta[d] + ((td[d] > th[d]) ? td[d] : th[d])) tt[d] = -1;
        end
        if (tt[d] >= 0) begin
          act[d]  = (tt[d] < ta[d] + th[d]);
          done[d] = (tt[d] >= ta[d]) && (tt[d] < ta[d] + td[d]);
        end else begin
          act[d]  = 1'b0;
          done[d] = spur_en && ($urandom_range(0, 15) == 0);
        end
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    check_all();
    tx_step();
    dv = 2'b00;
  endtask

  task automatic wait_idle(input int maxc, input string name);
    int k;
    k = 0;
    while (!(ready == 2'b11 && exp_q[0].size() == 0 && exp_q[1].size() == 0 &&
             !m_await[0] && !m_await[1]) && k < maxc) begin
      cyc();
      k++;
    end
    chk({name, "_done_in_time"}, 0, k < maxc, 1);
  endtask

  task automatic expect_cap(input int d, input string name, input int cnt, input logic [63:0] e);
    chk({name, "_count"}, d, cap[d].size(), cnt);
    for (int i = 0; i < cnt; i++)
      if (i < cap[d].size()) chk({name, "_char"}, d, cap[d][i], e[8*(cnt-1-i) +: 8]);
    cap[d].delete();
  endtask

  initial begin
    dv = 2'b00; byt[0] = 8'h00; byt[1] = 8'h00; act = 2'b00; done = 2'b00;
    prev_dv = 2'b00; spur_en = 1'b0; force_slow = 1'b0;
    tt[0] = -1; tt[1] = -1; ovcnt[0] = 0; ovcnt[1] = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #5;
    chk("reset_ready", 0, ready[0], 1);
    chk("reset_overrun", 0, ov[0], 0);
    chk("reset_tx_dv", 0, txdv[0], 0);
    chk("reset_tx_byte", 0, txb[0], 8'h00);
    chk("reset_ready", 1, ready[1], 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // 0x3A on the CRLF instance, 0x00 on the two-char instance, transmitters idle.
    dv = 2'b11; byt[0] = 8'h3A; byt[1] = 8'h00;
    cyc();
    chk("accept_drops_ready", 0, ready[0], 0);
    chk("no_strobe_yet", 0, txdv[0], 0);
    cyc();
    chk("first_strobe_latency", 0, txdv[0], 1);
    chk("first_strobe_byte", 0, txb[0], 8'h33);
    wait_idle(300, "line_3A");
    expect_cap(0, "hex_3A", 4, 64'h33410D0A);
    expect_cap(1, "hex_00", 2, 64'h3030);

    dv = 2'b11; byt[0] = 8'hFF; byt[1] = 8'hFF;
    cyc();
    wait_idle(300, "line_FF");
    expect_cap(0, "hex_FF_upper", 4, 64'h46460D0A);
    expect_cap(1, "hex_FF_lower", 2, 64'h6666);

    // Overrun while the first character is on the wire.
    ovcnt[0] = 0;
    dv[0] = 1'b1; byt[0] = 8'h12;
    cyc();
    n = 0;
    while (cap[0].size() == 0 && n < 100) begin cyc(); n++; end
    chk("overrun_first_strobe_seen", 0, n < 100, 1);
    cyc();
    dv[0] = 1'b1; byt[0] = 8'h34;
    cyc();
    wait_idle(300, "overrun_line");
    expect_cap(0, "overrun_line", 4, 64'h31320D0A);
    chk("overrun_pulse_count", 0, ovcnt[0], 1);

    // Back-to-back acceptance with long Done and lingering Active.
    force_slow = 1'b1; ovcnt[0] = 0;
    dv[0] = 1'b1; byt[0] = 8'hA5;
    cyc();
    n = 0;
    while (ready[0] == 1'b0 && n < 500) begin cyc(); n++; end
    chk("b2b_ready_returns", 0, n < 500, 1);
    dv[0] = 1'b1; byt[0] = 8'h5A;
    cyc();
    wait_idle(600, "back_to_back");
    expect_cap(0, "back_to_back", 8, 64'h41350D0A35410D0A);
    chk("b2b_no_overrun", 0, ovcnt[0], 0);
    force_slow = 1'b0;

    // Reset during WAIT_DONE of char[1].
    dv[0] = 1'b1; byt[0] = 8'h55;
    cyc();
    n = 0;
    while (cap[0].size() < 2 && n < 200) begin cyc(); n++; end
    chk("reset_test_two_strobes", 0, n < 200, 1);
    cyc();
    rst_n = 1'b0;
    #1;
    chk("async_reset_ready", 0, ready[0], 1);
    chk("async_reset_overrun", 0, ov[0], 0);
    chk("async_reset_tx_dv", 0, txdv[0], 0);
    chk("async_reset_tx_byte", 0, txb[0], 8'h00);
    cyc();
    rst_n = 1'b1;
    repeat (20) cyc();
    expect_cap(0, "abandoned_line", 2, 64'h3535);
    dv[0] = 1'b1; byt[0] = 8'h7E;
    cyc();
    wait_idle(300, "line_7E");
    expect_cap(0, "hex_7E", 4, 64'h37450D0A);

    // Random traffic with overruns and stray Done pulses.
    spur_en = 1'b1;
    cap[0].delete(); cap[1].delete();
    for (int c = 0; c < 4000; c++) begin
      cyc();
      for (int d = 0; d < 2; d++) begin
        dv[d]  = ($urandom_range(0, 7) == 0);
        byt[d] = 8'($urandom);
      end
    end
    cyc();
    spur_en = 1'b0;
    wait_idle(600, "random_drain");
    chk("random_activity", 0, cap[0].size() > 50, 1);
    chk("random_activity", 1, cap[1].size() > 50, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
